// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_bus_arbiter: round-robin share of one sync memory port (cpu0/loader)  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] C_WAIT_LAST = 4'(WAIT_STATES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              win_q, win_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic w_winner;
  logic w_done;
  logic w_rd_done;

  // On a tie the requester that did not win last time gets the port.
  assign w_winner = (cpu_req && dbg_req) ? ~last_grant_q : dbg_req;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d      = S_ACCESS;
          cnt_d        = 4'd0;
          win_d        = w_winner;
          last_grant_d = w_winner;
          wr_d         = w_winner ? dbg_wr    : cpu_wr;
          addr_d       = w_winner ? dbg_addr  : cpu_addr;
          wdata_d      = w_winner ? dbg_wdata : cpu_wdata;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_WAIT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          if (win_q) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Memory data only becomes valid in DONE, so it is forwarded there and held afterwards.
  assign w_done    = (state_q == S_DONE);
  assign w_rd_done = w_done && !wr_q;

  assign cpu_ack   = w_done && !win_q;
  assign dbg_ack   = w_done && win_q;
  assign cpu_rdata = (w_rd_done && !win_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (w_rd_done && win_q)  ? mem_rdata : dbg_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == S_ACCESS) && wr_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = win_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_bus_arbiter: directed checks of arbitration, timing and reset      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance, WAIT_STATES = 1
  logic        cpu_req = 0, cpu_wr = 0, dbg_req = 0, dbg_wr = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [15:0] u1_cpu_rdata, u1_dbg_rdata, u1_mem_addr, u1_mem_wdata, u1_rd;
  logic        u1_cpu_ack, u1_dbg_ack, u1_mem_we, u1_busy, u1_grant;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(u1_cpu_rdata), .cpu_ack(u1_cpu_ack),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(u1_dbg_rdata), .dbg_ack(u1_dbg_ack),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_we(u1_mem_we),
    .mem_rdata(u1_rd), .busy(u1_busy), .grant_id(u1_grant)
  );

  logic [15:0] mem [0:255];
  logic        pre_we = 0;
  logic [7:0]  pre_addr = 0;
  logic [15:0] pre_data = 0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (u1_mem_we) mem[u1_mem_addr[7:0]] <= u1_mem_wdata;
    u1_rd <= mem[u1_mem_addr[7:0]];
  end

  // Latency-only instances, memory returns address ^ 0x5A5A
  logic        r0_req = 0, r15_req = 0;
  logic [15:0] r0_addr = 0, r15_addr = 0;
  logic [15:0] u0_cpu_rdata, u0_dbg_rdata, u0_mem_addr, u0_mem_wdata, u0_rd;
  logic        u0_cpu_ack, u0_dbg_ack, u0_mem_we, u0_busy, u0_grant;
  logic [15:0] u15_cpu_rdata, u15_dbg_rdata, u15_mem_addr, u15_mem_wdata, u15_rd;
  logic        u15_cpu_ack, u15_dbg_ack, u15_mem_we, u15_busy, u15_grant;
  always @(posedge clk) begin
    u0_rd  <= u0_mem_addr ^ 16'h5A5A;
    u15_rd <= u15_mem_addr ^ 16'h5A5A;
  end

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(r0_req), .cpu_wr(1'b0), .cpu_addr(r0_addr), .cpu_wdata(16'h0),
    .cpu_rdata(u0_cpu_rdata), .cpu_ack(u0_cpu_ack),
    .dbg_req(1'b0), .dbg_wr(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_rdata(u0_dbg_rdata), .dbg_ack(u0_dbg_ack),
    .mem_addr(u0_mem_addr), .mem_wdata(u0_mem_wdata), .mem_we(u0_mem_we),
    .mem_rdata(u0_rd), .busy(u0_busy), .grant_id(u0_grant)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(15)) u15 (
    .clk(clk), .reset(reset),
    .cpu_req(r15_req), .cpu_wr(1'b0), .cpu_addr(r15_addr), .cpu_wdata(16'h0),
    .cpu_rdata(u15_cpu_rdata), .cpu_ack(u15_cpu_ack),
    .dbg_req(1'b0), .dbg_wr(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_rdata(u15_dbg_rdata), .dbg_ack(u15_dbg_ack),
    .mem_addr(u15_mem_addr), .mem_wdata(u15_mem_wdata), .mem_we(u15_mem_we),
    .mem_rdata(u15_rd), .busy(u15_busy), .grant_id(u15_grant)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request must already be raised; returns edges counted until ack is seen (0 = timeout).
  task automatic wait_ack(input bit who, output int lat, output int we_cyc, output int wrong_ack);
    lat = 0; we_cyc = 0; wrong_ack = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (u1_mem_we) we_cyc++;
      if (who ? u1_cpu_ack : u1_dbg_ack) wrong_ack++;
      if (who ? u1_dbg_ack : u1_cpu_ack) begin
        lat = i;
        if (who) dbg_req = 0; else cpu_req = 0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_cyc, wrong, acks, addr_bad, busy_cnt;
    int ack_t [4];
    logic ack_id [4];
    logic [15:0] rd_obs;

    // Reset and memory preload
    pre_we = 1; pre_addr = 8'h03; pre_data = 16'hA500;
    @(negedge clk); pre_addr = 8'hFF; pre_data = 16'hDEAD;
    @(negedge clk); pre_we = 0;
    chk("rst_busy", u1_busy, 0);
    chk("rst_we", u1_mem_we, 0);
    chk("rst_acks", {u1_cpu_ack, u1_dbg_ack}, 0);
    chk("rst_grant", u1_grant, 0);
    chk("rst_rdata", {u1_cpu_rdata, u1_dbg_rdata}, 0);
    chk("rst_addr", u1_mem_addr, 0);
    reset = 1;
    @(negedge clk);

    // 1: cpu read of 0x0003
    cpu_wr = 0; cpu_addr = 16'h0003; cpu_req = 1;
    wait_ack(0, lat, we_cyc, wrong);
    chk("t1_lat", lat, 3);
    chk("t1_rdata", u1_cpu_rdata, 16'hA500);
    chk("t1_we", we_cyc, 0);
    chk("t1_other_ack", wrong, 0);
    @(negedge clk);
    chk("t1_ack_once", u1_cpu_ack, 0);
    chk("t1_rdata_hold", u1_cpu_rdata, 16'hA500);
    @(negedge clk);

    // 2: loader write 0x81F0 to 0x0010, then read it back
    dbg_wr = 1; dbg_addr = 16'h0010; dbg_wdata = 16'h81F0; dbg_req = 1;
    wait_ack(1, lat, we_cyc, wrong);
    chk("t2_lat", lat, 3);
    chk("t2_we_cycles", we_cyc, 2);
    chk("t2_other_ack", wrong, 0);
    chk("t2_grant", u1_grant, 1);
    chk("t2_addr", u1_mem_addr, 16'h0010);
    chk("t2_wdata", u1_mem_wdata, 16'h81F0);
    chk("t2_dbg_rdata", u1_dbg_rdata, 16'h0000);
    @(negedge clk);
    chk("t2_ack_once", u1_dbg_ack, 0);
    chk("t2_mem", mem[8'h10], 16'h81F0);
    dbg_wr = 0; dbg_req = 1;
    wait_ack(1, lat, we_cyc, wrong);
    chk("t2_rd_lat", lat, 3);
    chk("t2_rd_data", u1_dbg_rdata, 16'h81F0);
    chk("t2_cpu_rdata_kept", u1_cpu_rdata, 16'hA500);
    @(negedge clk);

    // 3: both held from reset, alternating grants every 4 cycles
    reset = 0;
    cpu_wr = 0; cpu_addr = 16'h0003; cpu_req = 1;
    dbg_wr = 0; dbg_addr = 16'h0010; dbg_req = 1;
    @(negedge clk);
    reset = 1;
    acks = 0; wrong = 0;
    for (int i = 1; i <= 30 && acks < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (u1_cpu_ack && u1_dbg_ack) wrong++;
      if (u1_cpu_ack || u1_dbg_ack) begin
        ack_t[acks]  = i;
        ack_id[acks] = u1_dbg_ack;
        chk($sformatf("t3_grant_id%0d", acks), u1_grant, u1_dbg_ack);
        if (acks == 0) chk("t3_cpu_rdata", u1_cpu_rdata, 16'hA500);
        if (acks == 1) chk("t3_dbg_rdata", u1_dbg_rdata, 16'h81F0);
        acks++;
      end
    end
    cpu_req = 0; dbg_req = 0;
    chk("t3_ack_count", acks, 4);
    chk("t3_both_ack", wrong, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < acks) begin
        chk($sformatf("t3_time%0d", k), ack_t[k], 3 + 4 * k);
        chk($sformatf("t3_id%0d", k), ack_id[k], k % 2);
      end
    end
    repeat (3) @(negedge clk);

    // 4: WAIT_STATES = 0 and 15
    r0_addr = 16'h0000; r0_req = 1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (u0_cpu_ack) begin lat = i; rd_obs = u0_cpu_rdata; r0_req = 0; break; end
    end
    chk("t4_ws0_lat", lat, 2);
    chk("t4_ws0_rdata", rd_obs, 16'h5A5A);
    r15_addr = 16'h0003; r15_req = 1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (u15_cpu_ack) begin lat = i; rd_obs = u15_cpu_rdata; r15_req = 0; break; end
    end
    chk("t4_ws15_lat", lat, 17);
    chk("t4_ws15_rdata", rd_obs, 16'h5A59);
    @(negedge clk);

    // 5: reset during ACCESS of a loader write
    dbg_wr = 1; dbg_addr = 16'h0020; dbg_wdata = 16'h1234; dbg_req = 1;
    @(posedge clk); @(negedge clk);
    chk("t5_we_before", u1_mem_we, 1);
    chk("t5_busy_before", u1_busy, 1);
    #2 reset = 0;
    #1;
    chk("t5_we_async", u1_mem_we, 0);
    chk("t5_busy_async", u1_busy, 0);
    chk("t5_ack_async", u1_dbg_ack, 0);
    chk("t5_grant_async", u1_grant, 0);
    dbg_req = 0; dbg_wr = 0;
    @(negedge clk); reset = 1;
    busy_cnt = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (u1_busy || u1_dbg_ack || u1_cpu_ack) busy_cnt++;
    end
    chk("t5_idle_after", busy_cnt, 0);

    // 6: cpu drops req and moves its address mid-access
    cpu_wr = 0; cpu_addr = 16'h0010; cpu_req = 1;
    @(posedge clk); @(negedge clk);
    chk("t6_busy", u1_busy, 1);
    cpu_req = 0; cpu_addr = 16'hFFFF;
    acks = 0; lat = 0; addr_bad = 0; rd_obs = 0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (u1_busy && u1_mem_addr !== 16'h0010) addr_bad++;
      if (u1_cpu_ack) begin
        acks++;
        if (lat == 0) begin lat = i; rd_obs = u1_cpu_rdata; end
      end
    end
    chk("t6_ack_count", acks, 1);
    chk("t6_lat", lat, 3);
    chk("t6_rdata", rd_obs, 16'h81F0);
    chk("t6_addr_latched", addr_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
